// File: rtl/rs_decode_sequencer.sv
// rs_decode_sequencer: feeds one buffered codeword symbol-by-symbol into a
// Reed-Solomon decoder core, then collects the per-symbol error values the
// core returns. The result is held until it is handed off.
// A collect timeout bounds how long the sequencer waits for the core.
// Optional feature macro: RS_DEC_SEQ_CORRECT_EN adds out_corr_data, which is
// the buffered codeword XOR the collected error values.
module rs_decode_sequencer #(
  parameter int SYM_W       = 8,
  parameter int N_SYM       = 200,
  parameter int TIMEOUT_CYC = 1024,
  localparam int CW         = $clog2(N_SYM + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_SYM*SYM_W-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_SYM*SYM_W-1:0]   out_err_sym,
`ifdef RS_DEC_SEQ_CORRECT_EN
  output logic [N_SYM*SYM_W-1:0]   out_corr_data,
`endif
  output logic [CW-1:0]            out_err_cnt,
  output logic                     out_with_error,
  output logic                     out_timeout,
  output logic                     busy,
  output logic [SYM_W-1:0]         core_x,
  output logic                     core_enable,
  output logic                     core_clrn,
  input  logic [SYM_W-1:0]         core_error,
  input  logic                     core_valid
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] N_IDX   = CW'(N_SYM);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FEED    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SYM_W-1:0]   r_cw  [N_SYM];
  logic [SYM_W-1:0]   r_err [N_SYM];
  logic [CW-1:0]      r_feed_idx;
  logic [CW-1:0]      r_cap_idx;
  logic [CW-1:0]      r_err_cnt;
  logic               r_with_error;
  logic               r_timeout;
  logic [TW-1:0]      r_to_cnt;
  logic [SYM_W-1:0]   r_core_x;
  logic               r_core_en;
  logic               w_accept;
  logic               w_cap_fire;
  logic               w_feed_end;
  logic               w_set_timeout;

  // Next-state decode plus the per-cycle accept/capture/timeout strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_cap_fire    = 1'b0;
    w_feed_end    = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_FEED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FEED: begin
        w_cap_fire = core_valid & (r_cap_idx != N_IDX);
        if (r_feed_idx == N_IDX) begin
          w_feed_end  = 1'b1;
          w_state_nxt = ST_COLLECT;
        end else begin
          w_state_nxt = ST_FEED;
        end
      end
      ST_COLLECT: begin
        w_cap_fire = core_valid & (r_cap_idx != N_IDX);
        if (r_cap_idx == N_IDX) begin
          w_state_nxt = ST_DONE;
        end else if (r_to_cnt == TO_LAST) begin
          // A capture landing on the timeout edge still completes the codeword.
          w_state_nxt   = ST_DONE;
          w_set_timeout = ~(w_cap_fire & (r_cap_idx == (N_IDX - CW'(1))));
        end else begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; the synchronous clear overrides every other input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (!clr_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: codeword buffer, symbol feed, error capture, counters, timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SYM; i++) begin
        r_cw[i]  <= '0;
        r_err[i] <= '0;
      end
      r_feed_idx   <= '0;
      r_cap_idx    <= '0;
      r_err_cnt    <= '0;
      r_with_error <= 1'b0;
      r_timeout    <= 1'b0;
      r_to_cnt     <= '0;
      r_core_x     <= '0;
      r_core_en    <= 1'b0;
    end else if (!clr_n) begin
      for (int i = 0; i < N_SYM; i++) begin
        r_cw[i]  <= '0;
        r_err[i] <= '0;
      end
      r_feed_idx   <= '0;
      r_cap_idx    <= '0;
      r_err_cnt    <= '0;
      r_with_error <= 1'b0;
      r_timeout    <= 1'b0;
      r_to_cnt     <= '0;
      r_core_x     <= '0;
      r_core_en    <= 1'b0;
    end else if (w_accept) begin
      // Symbol 0 goes out on the cycle right after acceptance.
      for (int i = 0; i < N_SYM; i++) begin
        r_cw[i]  <= in_data[i*SYM_W +: SYM_W];
        r_err[i] <= '0;
      end
      r_feed_idx   <= CW'(1);
      r_cap_idx    <= '0;
      r_err_cnt    <= '0;
      r_with_error <= 1'b0;
      r_timeout    <= 1'b0;
      r_to_cnt     <= '0;
      r_core_x     <= in_data[SYM_W-1:0];
      r_core_en    <= 1'b1;
    end else begin
      if (w_feed_end) begin
        r_core_en <= 1'b0;
        r_core_x  <= '0;
        r_to_cnt  <= '0;
      end else if (r_state == ST_FEED) begin
        r_core_x   <= r_cw[r_feed_idx];
        r_feed_idx <= r_feed_idx + CW'(1);
      end
      if (r_state == ST_COLLECT) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
      if (w_cap_fire) begin
        r_err[r_cap_idx] <= core_error;
        r_cap_idx        <= r_cap_idx + CW'(1);
        if (core_error != '0) begin
          r_err_cnt    <= r_err_cnt + CW'(1);
          r_with_error <= 1'b1;
        end
      end
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N_SYM; gi++) begin : g_pack
    assign out_err_sym[gi*SYM_W +: SYM_W] = r_err[gi];
`ifdef RS_DEC_SEQ_CORRECT_EN
    assign out_corr_data[gi*SYM_W +: SYM_W] = r_cw[gi] ^ r_err[gi];
`endif
  end

  assign in_ready       = (r_state == ST_IDLE);
  assign busy           = (r_state != ST_IDLE);
  assign out_valid      = (r_state == ST_DONE);
  assign out_err_cnt    = r_err_cnt;
  assign out_with_error = r_with_error;
  assign out_timeout    = r_timeout;
  assign core_x         = r_core_x;
  assign core_enable    = r_core_en;
  assign core_clrn      = rst_n & clr_n;

endmodule
